// File: rtl/sram_rr_arbiter_pkg.sv
// sram_arb_pkg: shared geometry, request id and pending-response types for the SRAM arbiter.
package sram_arb_pkg;

    localparam int SRAM_DEPTH     = 384;
    localparam int SRAM_WIDTH     = 128;
    localparam int SRAM_ADDR_BITS = 9;

    localparam logic [SRAM_ADDR_BITS-1:0] DEPTH_LIM = SRAM_ADDR_BITS'(SRAM_DEPTH);

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    we;
        logic    err;
    } pend_t;

    function automatic logic addr_in_range(input logic [SRAM_ADDR_BITS-1:0] a);
        return a < DEPTH_LIM;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// sram_rr_arbiter_if: one requester's valid/ready request channel plus its response pulse.
interface sram_rr_arbiter_if;
    import sram_arb_pkg::*;

    logic                      valid;
    logic                      ready;
    logic                      we;
    logic [SRAM_ADDR_BITS-1:0] addr;
    logic [SRAM_WIDTH-1:0]     wdata;
    logic                      rsp_valid;
    logic                      rsp_err;
    logic [SRAM_WIDTH-1:0]     rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a priority pointer that flips to the loser after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);
    logic ptr_q, ptr_d;

    // Grants are held off during reset so ready never rises while rst is high.
    always_comb begin
        grant_o = rst ? 2'b00 : (&valid_i ? (ptr_q ? 2'b10 : 2'b01) : valid_i);
        ptr_d   = |grant_o ? ~grant_o[1] : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-requester round-robin front end for the 384x128 single-port SRAM,
// with range checking and a one-cycle response path routed back to the issuing requester.
module sram_rr_arbiter
    import sram_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    sram_rr_arbiter_if.slave          req0_if,
    sram_rr_arbiter_if.slave          req1_if,
    output logic                      sram_csb_o,
    output logic                      sram_web_o,
    output logic [SRAM_ADDR_BITS-1:0] sram_addr_o,
    output logic [SRAM_WIDTH-1:0]     sram_din_o,
    input  logic [SRAM_WIDTH-1:0]     sram_dout_i
);
    logic [1:0]                grant;
    logic                      any_grant;
    req_id_t                   win_id;
    logic                      win_we;
    logic [SRAM_ADDR_BITS-1:0] win_addr;
    logic [SRAM_WIDTH-1:0]     win_wdata;
    logic                      win_ok;
    logic                      access;
    logic                      rsp_hit;
    logic [SRAM_WIDTH-1:0]     rsp_data;
    pend_t                     pend_q, pend_d;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i ({req1_if.valid, req0_if.valid}),
        .grant_o (grant)
    );

    always_comb begin
        any_grant = |grant;
        win_id    = grant[1];
        win_we    = grant[1] ? req1_if.we    : req0_if.we;
        win_addr  = grant[1] ? req1_if.addr  : req0_if.addr;
        win_wdata = grant[1] ? req1_if.wdata : req0_if.wdata;
        win_ok    = addr_in_range(win_addr);
        access    = any_grant & win_ok;
        pend_d    = '{valid: any_grant, id: win_id, we: win_we, err: any_grant & ~win_ok};
    end

    assign req0_if.ready = grant[0];
    assign req1_if.ready = grant[1];

    // Out-of-range grants never select the SRAM; they only produce an error response.
    assign sram_csb_o  = ~access;
    assign sram_web_o  = ~(access & win_we);
    assign sram_addr_o = access ? win_addr  : '0;
    assign sram_din_o  = access ? win_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    // Gating with rst drops a response whose cycle coincides with reset.
    always_comb begin
        rsp_hit  = pend_q.valid & ~rst;
        rsp_data = (pend_q.we | pend_q.err) ? '0 : sram_dout_i;
    end

    assign req0_if.rsp_valid = rsp_hit & (pend_q.id == 1'b0);
    assign req1_if.rsp_valid = rsp_hit & (pend_q.id == 1'b1);
    assign req0_if.rsp_err   = req0_if.rsp_valid & pend_q.err;
    assign req1_if.rsp_err   = req1_if.rsp_valid & pend_q.err;
    assign req0_if.rsp_rdata = req0_if.rsp_valid ? rsp_data : '0;
    assign req1_if.rsp_rdata = req1_if.rsp_valid ? rsp_data : '0;

endmodule
